// File: rtl/sdram_cmd_seq.sv
// SDRAM command sequencer: one ACTIVE/READ|WRITE/PRECHARGE access per request.
// Optional auto-refresh is built when SDRAM_AUTO_REFRESH_EN is defined.
module sdram_cmd_seq #(
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int CAS_LAT   = 2,
  parameter int BURST_LEN = 4,
  parameter int T_RFC     = 7,
  parameter int REF_INT   = 780
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic write,
  output logic ready,
  output logic done,
  output logic cs_bar,
  output logic ras_bar,
  output logic cas_bar,
  output logic we_bar,
  output logic selrow,
  output logic selcol,
  output logic EnWdata,
  output logic EnRdata
);

  localparam int M1    = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int M2    = (M1 > CAS_LAT) ? M1 : CAS_LAT;
  localparam int M3    = (M2 > BURST_LEN) ? M2 : BURST_LEN;
  localparam int MAX_T = (M3 > T_RFC) ? M3 : T_RFC;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  if (T_RCD < 1 || T_RP < 1 || T_RFC < 1 || REF_INT < 2 ||
      !(CAS_LAT == 2 || CAS_LAT == 3) ||
      !(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_param_check
    $error("sdram_cmd_seq: illegal parameter value");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD, S_RDWR, S_CAS, S_BURST, S_PRE, S_RP
`ifdef SDRAM_AUTO_REFRESH_EN
    , S_REF, S_RFC
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          selrow_q, selrow_d;
  logic          selcol_q, selcol_d;
  logic          enw_q, enw_d;
  logic          enr_q, enr_d;
  logic          pend_now;

`ifdef SDRAM_AUTO_REFRESH_EN
  localparam int RW = $clog2(REF_INT);
  localparam logic [3:0] CMD_REF = 4'b0001;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pend_q, pend_d;
  logic          expire, pend_clr;
`endif

  // Next state and counter; every timed state leaves when the counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
`ifdef SDRAM_AUTO_REFRESH_EN
    pend_clr = 1'b0;
    expire   = (rcnt_q == '0);
    rcnt_d   = expire ? RW'(REF_INT - 1) : rcnt_q - RW'(1);
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SDRAM_AUTO_REFRESH_EN
        if (pend_q) begin
          state_d  = S_REF;
          pend_clr = 1'b1;
        end else
`endif
        if (req) begin
          state_d = S_ACT;
          wr_d    = write;
        end
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_RCD;
          cnt_d   = CW'(T_RCD - 2);
        end else begin
          state_d = S_RDWR;
        end
      end
      S_RCD: begin
        if (cnt_q == '0) state_d = S_RDWR;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RDWR: begin
        if (!wr_q) begin
          state_d = S_CAS;
          cnt_d   = CW'(CAS_LAT - 2);
        end else if (BURST_LEN > 1) begin
          state_d = S_BURST;
          cnt_d   = CW'(BURST_LEN - 2);
        end else begin
          state_d = S_PRE;
        end
      end
      S_CAS: begin
        if (cnt_q == '0) begin
          state_d = S_BURST;
          cnt_d   = CW'(BURST_LEN - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BURST: begin
        if (cnt_q == '0) state_d = S_PRE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_d = S_RP;
          cnt_d   = CW'(T_RP - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
`ifdef SDRAM_AUTO_REFRESH_EN
      S_REF: begin
        if (T_RFC > 1) begin
          state_d = S_RFC;
          cnt_d   = CW'(T_RFC - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RFC: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef SDRAM_AUTO_REFRESH_EN
    // A fresh expiry wins over the clear, and a repeat expiry just keeps the flag.
    pend_d   = expire | (pend_q & ~pend_clr);
    pend_now = pend_d;
`else
    pend_now = 1'b0;
`endif
  end

  // Outputs are decoded from the upcoming state so they can be registered.
  always_comb begin
    cmd_d    = CMD_NOP;
    selrow_d = 1'b0;
    selcol_d = 1'b0;
    enw_d    = 1'b0;
    enr_d    = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_ACT: begin
        cmd_d    = CMD_ACT;
        selrow_d = 1'b1;
      end
      S_RDWR: begin
        cmd_d    = wr_d ? CMD_WRITE : CMD_READ;
        selcol_d = 1'b1;
        enw_d    = wr_d;
      end
      S_BURST: begin
        enw_d = wr_d;
        enr_d = !wr_d;
      end
      S_PRE: begin
        cmd_d  = CMD_PRE;
        done_d = (T_RP == 1);
      end
      S_RP: done_d = (cnt_d == '0);
`ifdef SDRAM_AUTO_REFRESH_EN
      S_REF: cmd_d = CMD_REF;
`endif
      default: cmd_d = CMD_NOP;
    endcase
    ready_d = (state_d == S_IDLE) && !pend_now;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      cmd_q    <= CMD_DESEL;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      selrow_q <= 1'b0;
      selcol_q <= 1'b0;
      enw_q    <= 1'b0;
      enr_q    <= 1'b0;
`ifdef SDRAM_AUTO_REFRESH_EN
      rcnt_q   <= RW'(REF_INT - 1);
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      cmd_q    <= cmd_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      selrow_q <= selrow_d;
      selcol_q <= selcol_d;
      enw_q    <= enw_d;
      enr_q    <= enr_d;
`ifdef SDRAM_AUTO_REFRESH_EN
      rcnt_q   <= rcnt_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign {cs_bar, ras_bar, cas_bar, we_bar} = cmd_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign selrow  = selrow_q;
  assign selcol  = selcol_q;
  assign EnWdata = enw_q;
  assign EnRdata = enr_q;

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Bench for sdram_cmd_seq: four parameterisations share stimulus; a timeline model
// predicts every output each cycle, and literal traces pin the key scenarios.
module tb_sdram_cmd_seq;

  // dut0 default, dut1 CAS_LAT=3, dut2 BURST_LEN=1/T_RCD=1, dut3 REF_INT=20
  localparam int P_RCD [4] = '{2, 2, 1, 2};
  localparam int P_CL  [4] = '{2, 3, 2, 2};
  localparam int P_BL  [4] = '{4, 4, 1, 4};
  localparam int P_RP  [4] = '{2, 2, 2, 2};
  localparam int P_RFC [4] = '{7, 7, 7, 7};
  localparam int P_RI  [4] = '{780, 780, 780, 20};

  logic clk = 1'b0;
  logic reset;
  logic req;
  logic write;
  logic [3:0] cs_b, ras_b, cas_b, we_b, rdy, dn, srow, scol, enw, enr;

  always #5 clk = ~clk;

  sdram_cmd_seq u0 (
    .clk(clk), .reset(reset), .req(req), .write(write), .ready(rdy[0]), .done(dn[0]),
    .cs_bar(cs_b[0]), .ras_bar(ras_b[0]), .cas_bar(cas_b[0]), .we_bar(we_b[0]),
    .selrow(srow[0]), .selcol(scol[0]), .EnWdata(enw[0]), .EnRdata(enr[0]));
  sdram_cmd_seq #(.CAS_LAT(3)) u1 (
    .clk(clk), .reset(reset), .req(req), .write(write), .ready(rdy[1]), .done(dn[1]),
    .cs_bar(cs_b[1]), .ras_bar(ras_b[1]), .cas_bar(cas_b[1]), .we_bar(we_b[1]),
    .selrow(srow[1]), .selcol(scol[1]), .EnWdata(enw[1]), .EnRdata(enr[1]));
  sdram_cmd_seq #(.BURST_LEN(1), .T_RCD(1)) u2 (
    .clk(clk), .reset(reset), .req(req), .write(write), .ready(rdy[2]), .done(dn[2]),
    .cs_bar(cs_b[2]), .ras_bar(ras_b[2]), .cas_bar(cas_b[2]), .we_bar(we_b[2]),
    .selrow(srow[2]), .selcol(scol[2]), .EnWdata(enw[2]), .EnRdata(enr[2]));
  sdram_cmd_seq #(.REF_INT(20)) u3 (
    .clk(clk), .reset(reset), .req(req), .write(write), .ready(rdy[3]), .done(dn[3]),
    .cs_bar(cs_b[3]), .ras_bar(ras_b[3]), .cas_bar(cas_b[3]), .we_bar(we_b[3]),
    .selrow(srow[3]), .selcol(scol[3]), .EnWdata(enw[3]), .EnRdata(enr[3]));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int n_done [4] = '{0, 0, 0, 0};
  int n_act  [4] = '{0, 0, 0, 0};
  int n_refc [4] = '{0, 0, 0, 0};
  logic [9:0] tr [4][16];

  // Model: cycle index since reset release, plus start cycle of the current access/refresh.
  int cyc = 0;
  bit busy  [4];
  bit mwr   [4];
  bit rbusy [4];
  bit pend  [4];
  int t0    [4];
  int rt0   [4];
  int acc_cnt [4] = '{0, 0, 0, 0};

  function automatic int last_beat(input int i, input bit w);
    return w ? P_RCD[i] + P_BL[i] : P_RCD[i] + P_CL[i] + P_BL[i];
  endfunction

  function automatic bit acc_busy(input int i);
    return busy[i] && (cyc - t0[i] <= last_beat(i, mwr[i]) + P_RP[i]);
  endfunction

  function automatic bit ref_busy(input int i);
    return rbusy[i] && (cyc - rt0[i] <= P_RFC[i]);
  endfunction

  // {cmd[3:0], ready, done, selrow, selcol, EnWdata, EnRdata}
  function automatic logic [9:0] exp_vec(input int i);
    int k, l;
    logic [3:0] c;
    logic r, d, sr, sc, ew, er;
    c = 4'b0111; r = 1'b0; d = 1'b0; sr = 1'b0; sc = 1'b0; ew = 1'b0; er = 1'b0;
    if (cyc == 0) return 10'b1111_1_00000;
    if (acc_busy(i)) begin
      k = cyc - t0[i];
      l = last_beat(i, mwr[i]);
      if (k == 1)                c = 4'b0011;
      else if (k == P_RCD[i] + 1) c = mwr[i] ? 4'b0100 : 4'b0101;
      else if (k == l + 1)        c = 4'b0010;
      d  = (k == l + P_RP[i]);
      sr = (k == 1);
      sc = (k == P_RCD[i] + 1);
      ew = mwr[i]  && k >= P_RCD[i] + 1 && k <= l;
      er = !mwr[i] && k >= P_RCD[i] + P_CL[i] + 1 && k <= l;
    end else if (ref_busy(i)) begin
      if (cyc - rt0[i] == 1) c = 4'b0001;
    end else begin
      r = !pend[i];
    end
    return {c, r, d, sr, sc, ew, er};
  endfunction

  function automatic logic [9:0] got_vec(input int i);
    return {cs_b[i], ras_b[i], cas_b[i], we_b[i], rdy[i], dn[i], srow[i], scol[i], enw[i], enr[i]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
        busy[i] = 1'b0; rbusy[i] = 1'b0; pend[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!acc_busy(i) && !ref_busy(i)) begin
          busy[i] = 1'b0; rbusy[i] = 1'b0;
          if (pend[i]) begin
            rbusy[i] = 1'b1; rt0[i] = cyc; pend[i] = 1'b0;
          end else if (req) begin
            busy[i] = 1'b1; t0[i] = cyc; mwr[i] = write; acc_cnt[i]++;
          end
        end
      end
      cyc++;
`ifdef SDRAM_AUTO_REFRESH_EN
      for (int i = 0; i < 4; i++) if (cyc % P_RI[i] == 0) pend[i] = 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        logic [9:0] g, e;
        g = got_vec(i);
        e = exp_vec(i);
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cycle_cmp dut%0d cyc %0d: got %b need %b", i, cyc, g, e);
        end
        if (g[4]) n_done[i]++;
        if (g[9:6] == 4'b0011) n_act[i]++;
        if (g[9:6] == 4'b0001) n_refc[i]++;
      end
    end
  end

  task automatic check(input string name, input logic [9:0] g, input logic [9:0] e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b need %b", name, g, e);
    end
  endtask

  task automatic check_int(input string name, input int g, input int e);
    n_tests++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s: got %0d need %0d", name, g, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // req is presented in cycle 0; outputs of cycles 1..n are captured at each negedge.
  task automatic run_access(input bit w, input int n);
    @(negedge clk); #1; req = 1'b1; write = w;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) tr[i][k] = got_vec(i);
      if (k == 1) begin
        #1; req = 1'b0; write = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; write = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", got_vec(0), 10'b1111_1_00000);
    #1; reset = 1'b0;
    idle(3);

    run_access(1'b1, 12);
    check("wr_c1_active", tr[0][1], 10'b0011_0_0_1_0_0_0);
    check("wr_c2_nop",    tr[0][2], 10'b0111_0_0_0_0_0_0);
    check("wr_c3_write",  tr[0][3], 10'b0100_0_0_0_1_1_0);
    check("wr_c6_beat",   tr[0][6], 10'b0111_0_0_0_0_1_0);
    check("wr_c7_pre",    tr[0][7], 10'b0010_0_0_0_0_0_0);
    check("wr_c8_done",   tr[0][8], 10'b0111_0_1_0_0_0_0);
    check("wr_c9_ready",  tr[0][9], 10'b0111_1_0_0_0_0_0);
    check("bl1_c2_write", tr[2][2], 10'b0100_0_0_0_1_1_0);
    check("bl1_c3_pre",   tr[2][3], 10'b0010_0_0_0_0_0_0);
    check("bl1_c4_done",  tr[2][4], 10'b0111_0_1_0_0_0_0);
    idle(15);

    run_access(1'b0, 12);
    check("rd_c3_read",   tr[0][3],  10'b0101_0_0_0_1_0_0);
    check("rd_c4_nop",    tr[0][4],  10'b0111_0_0_0_0_0_0);
    check("rd_c5_beat",   tr[0][5],  10'b0111_0_0_0_0_0_1);
    check("rd_c8_beat",   tr[0][8],  10'b0111_0_0_0_0_0_1);
    check("rd_c9_pre",    tr[0][9],  10'b0010_0_0_0_0_0_0);
    check("rd_c10_done",  tr[0][10], 10'b0111_0_1_0_0_0_0);
    check("rd_c11_ready", tr[0][11], 10'b0111_1_0_0_0_0_0);
    check("cl3_c5_nop",   tr[1][5],  10'b0111_0_0_0_0_0_0);
    check("cl3_c6_beat",  tr[1][6],  10'b0111_0_0_0_0_0_1);
    check("cl3_c9_beat",  tr[1][9],  10'b0111_0_0_0_0_0_1);
    check("cl3_c10_pre",  tr[1][10], 10'b0010_0_0_0_0_0_0);
    idle(15);

    // Reset in the middle of a read, then a fresh access.
    @(negedge clk); #1; req = 1'b1; write = 1'b0;
    @(negedge clk); #1; req = 1'b0;
    repeat (3) @(negedge clk);
    #1; reset = 1'b1; #1;
    check("rst_async_d0", got_vec(0), 10'b1111_1_00000);
    check("rst_async_d1", got_vec(1), 10'b1111_1_00000);
    repeat (2) @(negedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    check("rst_first_nop", got_vec(0), 10'b0111_1_00000);
    #1; req = 1'b1; write = 1'b0;
    @(negedge clk);
    check("rst_new_active", got_vec(0), 10'b0011_0_0_1_0_0_0);
    #1; req = 1'b0;
    idle(15);

    // req held high: back-to-back accesses with write wiggling after each acceptance.
    @(negedge clk); #1; req = 1'b1;
    repeat (60) begin
      @(negedge clk); #1; write = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    idle(30);

    // req toggled while busy must not start anything extra.
    begin
      int d0, a0;
      d0 = n_done[0]; a0 = n_act[0];
      @(negedge clk); #1; req = 1'b1; write = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk); #1; req = (k % 2 == 1);
      end
      req = 1'b0;
      idle(20);
      check_int("toggle_done_cnt", n_done[0] - d0, 1);
      check_int("toggle_act_cnt",  n_act[0] - a0, 1);
    end

    for (int i = 0; i < 4; i++) check_int($sformatf("act_vs_accept_dut%0d", i), n_act[i], acc_cnt[i]);
`ifdef SDRAM_AUTO_REFRESH_EN
    check_int("refresh_seen_dut3", int'(n_refc[3] > 0), 1);
`else
    for (int i = 0; i < 4; i++) check_int($sformatf("no_refresh_dut%0d", i), n_refc[i], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
